truth_table_sweep: RTL and testbench



---
 rtl/truth_table_sweep_pkg.sv | 16 +
 rtl/truth_table_sweep_counter.sv | 35 +++
 rtl/truth_table_sweep.sv | 154 +++++++++++++++
 tb/tb_truth_table_sweep.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweep_pkg.sv
// Shared definitions for the truth-table sweep stage.
// Holds the vector/table widths, settle-counter width and FSM state encoding.
package truth_table_sweep_pkg;

   localparam int unsigned NV = 4;   // stimulus vector width {w,x,y,z}
   localparam int unsigned NT = 16;  // truth-table width, one bit per vector
   localparam int unsigned SW = 4;   // settle counter width (SETTLE up to 15)

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/truth_table_sweep_counter.sv
// sweep_counter: vector index register for the sweep.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : load index with 0 (has priority over inc)
//   inc        : advance index by one
//   idx        : current index (registered)
//   last_c     : combinational flag, idx is the final vector (15)
module sweep_counter
   import truth_table_sweep_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [NV-1:0] idx,
   output logic          last_c
);

   logic [NV-1:0] idx_q;

   // Index register; clear wins over increment
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (clr) begin
         idx_q <= '0;
      end else if (inc) begin
         idx_q <= idx_q + NV'(1);
      end
   end

   assign idx    = idx_q;
   assign last_c = (idx_q == {NV{1'b1}});

endmodule

// File: rtl/truth_table_sweep.sv
// truth_table_sweep: walks all 16 {w,x,y,z} vectors through a function block,
// captures its s1/s2 outputs into two truth tables and compares them with
// the expected constants.
// Parameters:
//   SETTLE     : cycles each vector is held before its sample cycle (1..15)
//   EXP1, EXP2 : expected tables for s1, s2 (bit i = vector i)
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : sweep request, honoured only when idle
//   w, x, y, z     : stimulus vector, w is the MSB
//   s1_in, s2_in   : outputs of the function block under test
//   busy           : sweep in progress (start acceptance until DONE exits)
//   done           : one-cycle pulse when both tables are complete
//   pass           : both tables matched, valid with done and held after
//   tt1, tt2       : captured truth tables
//   idx            : current vector index
module truth_table_sweep
   import truth_table_sweep_pkg::*;
#(
   parameter int unsigned    SETTLE = 1,
   parameter logic [NT-1:0]  EXP1   = 16'h0000,
   parameter logic [NT-1:0]  EXP2   = 16'h0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          w,
   output logic          x,
   output logic          y,
   output logic          z,
   input  logic          s1_in,
   input  logic          s2_in,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [NT-1:0] tt1,
   output logic [NT-1:0] tt2,
   output logic [NV-1:0] idx
);

   localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);

   state_e        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [NV-1:0] vec_q, vec_d;
   logic [NT-1:0] tt1_q, tt1_d;
   logic [NT-1:0] tt2_q, tt2_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          cnt_clr, cnt_inc;
   logic          cnt_last_c;
   logic [NV-1:0] cnt_idx;

   sweep_counter u_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .idx    (cnt_idx),
      .last_c (cnt_last_c)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         vec_q    <= '0;
         tt1_q    <= '0;
         tt2_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         vec_q    <= vec_d;
         tt1_q    <= tt1_d;
         tt2_q    <= tt2_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   // Next-state and next-output logic; the vector register is driven with
   // the index the next state will present, so it returns to 0 outside a sweep
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      vec_d    = '0;
      tt1_d    = tt1_q;
      tt2_d    = tt2_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_APPLY;
               settle_d = SETTLE_M1;
               tt1_d    = '0;
               tt2_d    = '0;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
               cnt_clr  = 1'b1;
            end
         end
         ST_APPLY: begin
            vec_d = cnt_idx;
            if (settle_q == '0) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         ST_SAMPLE: begin
            tt1_d[cnt_idx] = s1_in;
            tt2_d[cnt_idx] = s2_in;
            if (cnt_last_c) begin
               // Compare including the bit-15 write happening at this edge
               state_d = ST_DONE;
               done_d  = 1'b1;
               pass_d  = (tt1_d == EXP1) && (tt2_d == EXP2);
            end else begin
               state_d  = ST_APPLY;
               settle_d = SETTLE_M1;
               cnt_inc  = 1'b1;
               vec_d    = cnt_idx + NV'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign {w, x, y, z} = vec_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;
   assign tt1  = tt1_q;
   assign tt2  = tt2_q;
   assign idx  = cnt_idx;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep. Unit A: SETTLE=1, s1=w&x, s2=~z,
// matching expectations. Unit B: same block, wrong EXP2. Unit C: SETTLE=3,
// s1=s2=w. All units share clock, reset and start.
module tb_truth_table_sweep;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;

   logic        a_w, a_x, a_y, a_z, a_busy, a_done, a_pass;
   logic [15:0] a_tt1, a_tt2;
   logic [3:0]  a_idx;
   logic        b_w, b_x, b_y, b_z, b_busy, b_done, b_pass;
   logic [15:0] b_tt1, b_tt2;
   logic [3:0]  b_idx;
   logic        c_w, c_x, c_y, c_z, c_busy, c_done, c_pass;
   logic [15:0] c_tt1, c_tt2;
   logic [3:0]  c_idx;

   int passed = 0;
   int total  = 0;
   int pulses;

   always #5 clk = ~clk;

   truth_table_sweep #(.SETTLE(1), .EXP1(16'hF000), .EXP2(16'h5555)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start),
      .w(a_w), .x(a_x), .y(a_y), .z(a_z),
      .s1_in(a_w & a_x), .s2_in(~a_z),
      .busy(a_busy), .done(a_done), .pass(a_pass),
      .tt1(a_tt1), .tt2(a_tt2), .idx(a_idx)
   );

   truth_table_sweep #(.SETTLE(1), .EXP1(16'hF000), .EXP2(16'h5554)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start),
      .w(b_w), .x(b_x), .y(b_y), .z(b_z),
      .s1_in(b_w & b_x), .s2_in(~b_z),
      .busy(b_busy), .done(b_done), .pass(b_pass),
      .tt1(b_tt1), .tt2(b_tt2), .idx(b_idx)
   );

   truth_table_sweep #(.SETTLE(3), .EXP1(16'hFF00), .EXP2(16'hFF00)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start),
      .w(c_w), .x(c_x), .y(c_y), .z(c_z),
      .s1_in(c_w), .s2_in(c_w),
      .busy(c_busy), .done(c_done), .pass(c_pass),
      .tt1(c_tt1), .tt2(c_tt2), .idx(c_idx)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive start for one edge (E0); returns 1ns after E0
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      tick();
      tick();
      chk("rst_busy", 16'(a_busy), 16'd0);
      chk("rst_done", 16'(a_done), 16'd0);
      chk("rst_pass", 16'(a_pass), 16'd0);
      chk("rst_tt1", a_tt1, 16'h0000);
      chk("rst_tt2", a_tt2, 16'h0000);
      chk("rst_idx", 16'(a_idx), 16'd0);
      chk("rst_vec", 16'({a_w, a_x, a_y, a_z}), 16'd0);
      rst_n = 1'b1;
      tick();

      // Sweep 1: all three units, k = edges since E0
      pulse_start();
      for (int k = 0; k <= 66; k++) begin
         if (k < 32) chk($sformatf("a_vec_k%0d", k), 16'({a_w, a_x, a_y, a_z}), 16'(k >> 1));
         if (k < 64) chk($sformatf("c_vec_k%0d", k), 16'({c_w, c_x, c_y, c_z}), 16'(k >> 2));
         chk($sformatf("a_done_k%0d", k), 16'(a_done), 16'(k == 32));
         chk($sformatf("c_done_k%0d", k), 16'(c_done), 16'(k == 64));
         chk($sformatf("a_busy_k%0d", k), 16'(a_busy), 16'(k <= 32));
         if (k == 32) begin
            chk("a_tt1", a_tt1, 16'hF000);
            chk("a_tt2", a_tt2, 16'h5555);
            chk("a_pass", 16'(a_pass), 16'd1);
            chk("a_idx_last", 16'(a_idx), 16'd15);
            chk("b_done", 16'(b_done), 16'd1);
            chk("b_tt2", b_tt2, 16'h5555);
            chk("b_pass", 16'(b_pass), 16'd0);
         end
         if (k == 33) begin
            chk("a_hold_pass", 16'(a_pass), 16'd1);
            chk("a_hold_idx", 16'(a_idx), 16'd15);
            chk("a_hold_tt1", a_tt1, 16'hF000);
            chk("a_idle_vec", 16'({a_w, a_x, a_y, a_z}), 16'd0);
         end
         if (k == 64) begin
            chk("c_tt1", c_tt1, 16'hFF00);
            chk("c_tt2", c_tt2, 16'hFF00);
            chk("c_pass", 16'(c_pass), 16'd1);
         end
         tick();
      end

      // Sweep 2: start re-pulsed mid-sweep is ignored
      pulse_start();
      pulses = 0;
      for (int k = 0; k <= 40; k++) begin
         if (k == 9)  start = 1'b1;
         if (k == 10) start = 1'b0;
         if (k == 0) chk("a_pass_cleared", 16'(a_pass), 16'd0);
         if (a_done) pulses++;
         chk($sformatf("rep_done_k%0d", k), 16'(a_done), 16'(k == 32));
         tick();
      end
      chk("rep_pulses", 16'(pulses), 16'd1);
      repeat (40) tick();

      // Sweep 3: reset asserted mid-sweep at edge E0+12
      pulse_start();
      for (int k = 0; k < 12; k++) begin
         if (k == 11) begin
            chk("pre_rst_tt2", a_tt2, 16'h0015);
            rst_n = 1'b0;
         end
         tick();
      end
      rst_n = 1'b1;
      chk("mid_rst_idx", 16'(a_idx), 16'd0);
      chk("mid_rst_vec", 16'({a_w, a_x, a_y, a_z}), 16'd0);
      chk("mid_rst_busy", 16'(a_busy), 16'd0);
      chk("mid_rst_tt1", a_tt1, 16'h0000);
      chk("mid_rst_tt2", a_tt2, 16'h0000);
      tick();
      chk("post_rst_idle", 16'(a_busy), 16'd0);
      pulse_start();
      for (int k = 0; k <= 33; k++) begin
         chk($sformatf("rs_done_k%0d", k), 16'(a_done), 16'(k == 32));
         if (k == 32) begin
            chk("rs_tt1", a_tt1, 16'hF000);
            chk("rs_tt2", a_tt2, 16'h5555);
            chk("rs_pass", 16'(a_pass), 16'd1);
         end
         tick();
      end

      // Sweep 4: start held high -> back-to-back sweeps
      start = 1'b1;
      tick();
      for (int k = 0; k < 100; k++) begin
         chk($sformatf("hold_done_k%0d", k), 16'(a_done), 16'(k == 32 || k == 66));
         if (k == 33) chk("hold_tt1_idle", a_tt1, 16'hF000);
         if (k == 34) begin
            chk("hold_tt1_clr", a_tt1, 16'h0000);
            chk("hold_tt2_clr", a_tt2, 16'h0000);
            chk("hold_busy", 16'(a_busy), 16'd1);
         end
         if (k == 66) chk("hold_pass2", 16'(a_pass), 16'd1);
         tick();
      end
      start = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
